// File: rtl/reg_bi_pkg.sv
// ============================================================================
// Module : reg_bi_pkg
// Shared datapath constants and helpers for the CPU bus registers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package reg_bi_pkg;

  localparam int unsigned C_DATA_W = 8;
  localparam logic [C_DATA_W-1:0] C_RESET_VAL = 8'h00;

  typedef logic [C_DATA_W-1:0] data_t;

  // Source chosen by the priority mux for the current edge
  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_DB     = 2'd1,
    SRC_INV_DB = 2'd2,
    SRC_ADL    = 2'd3
  } src_e;

  function automatic src_e pick_src(input logic db, input logic inv_db, input logic adl);
    if (db)          return SRC_DB;
    else if (inv_db) return SRC_INV_DB;
    else if (adl)    return SRC_ADL;
    else             return SRC_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_bi_bus_sel3.sv
// ============================================================================
// Module : bus_sel3
// Three-source priority select (A > inverted A > B) with a load strobe.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bus_sel3
  import reg_bi_pkg::*;
(
  input  logic  sel_a,
  input  logic  sel_a_inv,
  input  logic  sel_b,
  input  data_t data_a,
  input  data_t data_b,
  output logic  load,
  output data_t data
);

  src_e w_src;

  always_comb begin
    w_src = pick_src(sel_a, sel_a_inv, sel_b);
    load  = (w_src != SRC_NONE);
    case (w_src)
      SRC_DB:     data = data_a;
      SRC_INV_DB: data = ~data_a;
      SRC_ADL:    data = data_b;
      default:    data = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/reg_bi.sv
// ============================================================================
// Module : reg_bi
// ALU B-input holding register loaded from DB, inverted DB, or ADL.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module reg_bi
  import reg_bi_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       DB_LOAD,
  input  logic       INV_DB_LOAD,
  input  logic       ADL_LOAD,
  input  logic [7:0] ADL_DATA,
  input  logic [7:0] DB_DATA,
  output logic [7:0] TO_ALU
);

  logic  w_load;
  data_t w_next;
  data_t r_b;

  bus_sel3 u_sel (
    .sel_a     (DB_LOAD),
    .sel_a_inv (INV_DB_LOAD),
    .sel_b     (ADL_LOAD),
    .data_a    (DB_DATA),
    .data_b    (ADL_DATA),
    .load      (w_load),
    .data      (w_next)
  );

  always_ff @(posedge CLK) begin
    if (RST)
      r_b <= C_RESET_VAL;
    else if (w_load)
      r_b <= w_next;
  end

  assign TO_ALU = r_b;

endmodule

`default_nettype wire

// File: tb/tb_reg_bi.sv
// ============================================================================
// Module : tb_reg_bi
// Scoreboard bench for reg_bi: driver pushes expected values, monitor checks.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_reg_bi;

  logic       clk;
  logic       rst;
  logic       db_load;
  logic       inv_db_load;
  logic       adl_load;
  logic [7:0] adl_data;
  logic [7:0] db_data;
  logic [7:0] to_alu;

  typedef struct {
    logic [7:0] exp;
    string      tag;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] model_r  = 8'h00;
  bit         done     = 0;

  reg_bi dut (
    .CLK         (clk),
    .RST         (rst),
    .DB_LOAD     (db_load),
    .INV_DB_LOAD (inv_db_load),
    .ADL_LOAD    (adl_load),
    .ADL_DATA    (adl_data),
    .DB_DATA     (db_data),
    .TO_ALU      (to_alu)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the register value expected after the edge
  task automatic drive(input logic r, input logic d, input logic i, input logic a,
                       input logic [7:0] dd, input logic [7:0] ad, input string tag);
    exp_t e;
    @(negedge clk);
    rst = r; db_load = d; inv_db_load = i; adl_load = a;
    db_data = dd; adl_data = ad;
    if (r)      model_r = 8'h00;
    else if (d) model_r = dd;
    else if (i) model_r = 8'hFF - dd;
    else if (a) model_r = ad;
    e.exp = model_r;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Monitor: one output per edge once stimulus has queued an expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if (to_alu !== e.exp) begin
          n_errors++;
          $display("FAIL %s: TO_ALU=%02h expected=%02h", e.tag, to_alu, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout: simulation did not complete, errors=%0d", n_errors + 1);
      $fatal(1, "timeout");
    end
  end

  initial begin
    rst = 0; db_load = 0; inv_db_load = 0; adl_load = 0;
    db_data = 8'h00; adl_data = 8'h00;

    drive(1, 1, 0, 0, 8'hAA, 8'h00, "reset_wins");
    drive(1, 0, 0, 0, 8'h33, 8'h44, "reset_hold");
    drive(0, 1, 0, 0, 8'hAA, 8'hBB, "db_load");
    drive(0, 0, 0, 0, 8'h12, 8'hBB, "db_hold1");
    drive(0, 0, 0, 0, 8'h12, 8'h77, "db_hold2");
    drive(0, 0, 1, 0, 8'hAA, 8'hBB, "inv_load");
    drive(0, 0, 0, 1, 8'h00, 8'hBB, "adl_load");
    drive(0, 0, 0, 0, 8'hFF, 8'h01, "adl_hold");
    drive(0, 1, 1, 1, 8'h0F, 8'hBB, "prio_all");
    drive(0, 0, 1, 1, 8'h0F, 8'hBB, "prio_inv_adl");
    drive(0, 0, 0, 1, 8'h0F, 8'hBB, "prio_adl");
    drive(0, 1, 0, 0, 8'h01, 8'hBB, "cont_01");
    drive(0, 1, 0, 0, 8'h02, 8'hBB, "cont_02");
    drive(0, 1, 0, 0, 8'h03, 8'hBB, "cont_03");
    drive(1, 0, 1, 1, 8'h5A, 8'hA5, "reset_mid");
    drive(0, 0, 1, 0, 8'h00, 8'h00, "inv_zero");

    for (int k = 0; k < 300; k++) begin
      logic [3:0] ctl;
      ctl = 4'($urandom);
      drive(($urandom_range(0, 19) == 0), ctl[0], ctl[1], ctl[2],
            8'($urandom), 8'($urandom), "random");
    end

    @(negedge clk);
    rst = 0; db_load = 0; inv_db_load = 0; adl_load = 0;
    for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: pending=%0d expected=0", sb_q.size());
    end
    done = 1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
